// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave front end and spi_ram_burst.
// The master side drives commands; the slave side returns read data and
// error pulses.
interface spi_ram_burst_if #(
    parameter int PAYLOAD_W  = 8,
    parameter int DATA_WIDTH = 8
);
    logic [PAYLOAD_W+1:0]  din;
    logic                  rx_valid;
    logic                  wp;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  cmd_err;

    modport master (
        output din, rx_valid, wp,
        input  dout, tx_valid, cmd_err
    );

    modport slave (
        input  din, rx_valid, wp,
        output dout, tx_valid, cmd_err
    );
endinterface

// File: rtl/spi_ram_burst.sv
// Single-port memory slave behind the SPI receive path.
//
// Each cycle with rx_valid high, one 2-bit command is decoded:
//   00 load the write pointer, 01 write data,
//   10 load the read pointer,  11 read data.
// Data commands can post-increment their pointer, so long bursts only need
// one address load. Write and read pointers are independent and wrap.
//
// Outputs are registered. dout and tx_valid are zero unless the previous
// cycle held an accepted read. cmd_err pulses for one cycle after a rejected
// command: a write under write-protect, or a read before any read address
// has been loaded since reset. Memory contents are not touched by reset.
module spi_ram_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PAYLOAD_W  = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_ram_burst_if.slave     bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    // The payload field must be wide enough to hold an address and a data word.
    generate
        if ((PAYLOAD_W < ADDR_WIDTH) || (PAYLOAD_W < DATA_WIDTH)) begin : g_bad_params
            $error("spi_ram_burst: PAYLOAD_W must be >= ADDR_WIDTH and >= DATA_WIDTH");
        end
    endgenerate

    // Storage; deliberately without reset so contents survive rst_n.
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_loaded;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_tx_valid;
    logic                  r_cmd_err;

    logic [1:0]            w_cmd;
    logic [PAYLOAD_W-1:0]  w_payload;
    logic [ADDR_WIDTH-1:0] w_wr_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;
    logic                  w_rd_loaded_nxt;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic                  w_tx_valid_nxt;
    logic                  w_cmd_err_nxt;
    logic                  w_mem_we;

    assign w_cmd     = bus.din[PAYLOAD_W+1:PAYLOAD_W];
    assign w_payload = bus.din[PAYLOAD_W-1:0];

    // Decode the current command into next-state values for pointers and outputs.
    always_comb begin
        w_wr_addr_nxt   = r_wr_addr;
        w_rd_addr_nxt   = r_rd_addr;
        w_rd_loaded_nxt = r_rd_loaded;
        w_dout_nxt      = '0;
        w_tx_valid_nxt  = 1'b0;
        w_cmd_err_nxt   = 1'b0;
        w_mem_we        = 1'b0;
        if (bus.rx_valid) begin
            case (w_cmd)
                CMD_WR_ADDR: begin
                    w_wr_addr_nxt = w_payload[ADDR_WIDTH-1:0];
                end
                CMD_WR_DATA: begin
                    if (!bus.wp) begin
                        w_mem_we = 1'b1;
                        if (AUTO_INC != 0) begin
                            w_wr_addr_nxt = r_wr_addr + ADDR_ONE;
                        end else begin
                            w_wr_addr_nxt = r_wr_addr;
                        end
                    end else begin
                        // Protected write: pointer holds so the retry lands in place.
                        w_cmd_err_nxt = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    w_rd_addr_nxt   = w_payload[ADDR_WIDTH-1:0];
                    w_rd_loaded_nxt = 1'b1;
                end
                CMD_RD_DATA: begin
                    if (r_rd_loaded) begin
                        w_dout_nxt     = r_mem[r_rd_addr];
                        w_tx_valid_nxt = 1'b1;
                        if (AUTO_INC != 0) begin
                            w_rd_addr_nxt = r_rd_addr + ADDR_ONE;
                        end else begin
                            w_rd_addr_nxt = r_rd_addr;
                        end
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_cmd_err_nxt = 1'b0;
                end
            endcase
        end else begin
            w_mem_we = 1'b0;
        end
    end

    // Memory write port; the write is visible to a read on the following cycle.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_addr] <= w_payload[DATA_WIDTH-1:0];
        end
    end

    // Pointer and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_rd_loaded <= 1'b0;
            r_dout      <= '0;
            r_tx_valid  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_wr_addr   <= w_wr_addr_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_rd_loaded <= w_rd_loaded_nxt;
            r_dout      <= w_dout_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_cmd_err   <= w_cmd_err_nxt;
        end
    end

    assign bus.dout     = r_dout;
    assign bus.tx_valid = r_tx_valid;
    assign bus.cmd_err  = r_cmd_err;

endmodule
